// File: rtl/addr_router_pkg.sv
// Shared types and constants for the address router: FSM states, error codes
// and widths used by the router top and its decoder.
package addr_router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RSP,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned TIMER_W     = 16;
  localparam int unsigned ERR_COUNT_W = 8;

  // Select index width; a single slave still needs a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_router_decode.sv
// Combinational region decoder: compares the request's region field against
// each slave's region index and returns the lowest matching slave.
module addr_router_decode
  import addr_router_pkg::*;
#(
  parameter int NUM_SLAVES  = 6,
  parameter int ADDR_W      = 32,
  parameter int REGION_BITS = 16,
  parameter int SEL_W       = sel_width(NUM_SLAVES),
  parameter logic [NUM_SLAVES*(ADDR_W-REGION_BITS)-1:0] REGION_IDX =
    {16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h0}
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_hit
);

  localparam int RW = ADDR_W - REGION_BITS;

  logic [RW-1:0] w_region;

  assign w_region = i_addr[ADDR_W-1:REGION_BITS];

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    // Scan downwards so the lowest matching slave overwrites higher ones.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_region == REGION_IDX[i*RW +: RW]) begin
        o_hit = 1'b1;
        o_sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/addr_router.sv
// Single-master to NUM_SLAVES address router with valid/ready slave handshake,
// per-transaction timeout, registered error responses and sticky fault capture.
module addr_router
  import addr_router_pkg::*;
#(
  parameter int NUM_SLAVES  = 6,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REGION_BITS = 16,
  parameter logic [NUM_SLAVES*(ADDR_W-REGION_BITS)-1:0] REGION_IDX =
    {16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h0},
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m_req_valid,
  output logic                         m_req_ready,
  input  logic [ADDR_W-1:0]            m_req_addr,
  input  logic                         m_req_we,
  input  logic [DATA_W-1:0]            m_req_wdata,
  output logic                         m_rsp_valid,
  output logic [DATA_W-1:0]            m_rsp_rdata,
  output logic                         m_rsp_err,
  output logic [NUM_SLAVES-1:0]        s_req_valid,
  input  logic [NUM_SLAVES-1:0]        s_req_ready,
  output logic [ADDR_W-1:0]            s_addr,
  output logic                         s_we,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]        s_rsp_valid,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rsp_rdata,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [ERR_COUNT_W-1:0]       err_count,
  input  logic                         err_clear
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic                     r_alive;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_we;
  logic [DATA_W-1:0]        r_wdata;
  logic [SEL_W-1:0]         r_sel;
  logic [TIMER_W-1:0]       r_timer;
  logic [DATA_W-1:0]        r_rdata;
  logic                     r_err_valid;
  logic [1:0]               r_err_code;
  logic [ADDR_W-1:0]        r_err_addr;
  logic [ERR_COUNT_W-1:0]   r_err_count;

  logic                     w_hit;
  logic [SEL_W-1:0]         w_sel;
  logic                     w_accept;
  logic                     w_sel_req_ready;
  logic                     w_sel_rsp_valid;
  logic [DATA_W-1:0]        w_sel_rdata;
  logic                     w_timer_last;
  logic                     w_enter_err;
  logic                     w_err_valid_nxt;
  logic [1:0]               w_err_code_nxt;
  logic [ADDR_W-1:0]        w_err_addr_nxt;
  logic [ERR_COUNT_W-1:0]   w_err_count_nxt;

  addr_router_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .ADDR_W      (ADDR_W),
    .REGION_BITS (REGION_BITS),
    .SEL_W       (SEL_W),
    .REGION_IDX  (REGION_IDX)
  ) u_decode (
    .i_addr (m_req_addr),
    .o_sel  (w_sel),
    .o_hit  (w_hit)
  );

  assign w_accept        = m_req_valid && m_req_ready;
  assign w_sel_req_ready = s_req_ready[r_sel];
  assign w_sel_rsp_valid = s_rsp_valid[r_sel];
  assign w_sel_rdata     = s_rsp_rdata[int'(r_sel)*DATA_W +: DATA_W];
  assign w_timer_last    = (r_timer >= TIMER_LAST);
  assign w_enter_err     = (w_state_nxt == ERR) && (r_state != ERR);

  // r_alive holds m_req_ready low until the first edge after reset release,
  // so every output reads 0 while rst_n is asserted.
  always_comb begin
    w_state_nxt = r_state;
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_err   = 1'b0;
    m_rsp_rdata = '0;
    s_req_valid = '0;
    unique case (r_state)
      IDLE: begin
        m_req_ready = r_alive;
        if (w_accept) w_state_nxt = w_hit ? REQ : ERR;
      end
      REQ: begin
        s_req_valid = NUM_SLAVES'(1) << r_sel;
        if (w_timer_last)         w_state_nxt = ERR;
        else if (w_sel_req_ready) w_state_nxt = RSP;
      end
      RSP: begin
        // A response on the final allowed cycle still completes normally.
        if (w_sel_rsp_valid)   w_state_nxt = DONE;
        else if (w_timer_last) w_state_nxt = ERR;
      end
      DONE: begin
        m_rsp_valid = 1'b1;
        m_rsp_rdata = r_rdata;
        w_state_nxt = IDLE;
      end
      ERR: begin
        m_rsp_valid = 1'b1;
        m_rsp_err   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_timer <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= m_req_addr;
        r_we    <= m_req_we;
        r_wdata <= m_req_wdata;
        r_sel   <= w_sel;
        r_timer <= '0;
        r_rdata <= '0;
      end else if (r_state == REQ || r_state == RSP) begin
        r_timer <= r_timer + 1'b1;
      end
      if (r_state == RSP && w_sel_rsp_valid) begin
        r_rdata <= r_we ? '0 : w_sel_rdata;
      end
    end
  end

  assign s_addr  = r_addr;
  assign s_we    = r_we;
  assign s_wdata = r_wdata;

  // Clear is applied first so an error in the same cycle is captured fresh.
  always_comb begin
    w_err_valid_nxt = err_clear ? 1'b0 : r_err_valid;
    w_err_code_nxt  = err_clear ? 2'b00 : r_err_code;
    w_err_addr_nxt  = err_clear ? '0 : r_err_addr;
    w_err_count_nxt = err_clear ? '0 : r_err_count;
    if (w_enter_err) begin
      if (!w_err_valid_nxt) begin
        w_err_valid_nxt = 1'b1;
        w_err_code_nxt  = (r_state == IDLE) ? ERR_DECODE : ERR_TIMEOUT;
        w_err_addr_nxt  = (r_state == IDLE) ? m_req_addr : r_addr;
      end
      if (w_err_count_nxt != '1) w_err_count_nxt = w_err_count_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_code  <= 2'b00;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else begin
      r_err_valid <= w_err_valid_nxt;
      r_err_code  <= w_err_code_nxt;
      r_err_addr  <= w_err_addr_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_addr_router.sv
// Self-checking bench for addr_router: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_addr_router;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RB = 16;
  localparam int TO = 8;
  localparam logic [NS*(AW-RB)-1:0] RIDX = {16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m_req_valid = 1'b0;
  logic              m_req_ready;
  logic [AW-1:0]     m_req_addr = '0;
  logic              m_req_we = 1'b0;
  logic [DW-1:0]     m_req_wdata = '0;
  logic              m_rsp_valid;
  logic [DW-1:0]     m_rsp_rdata;
  logic              m_rsp_err;
  logic [NS-1:0]     s_req_valid;
  logic [NS-1:0]     s_req_ready = '0;
  logic [AW-1:0]     s_addr;
  logic              s_we;
  logic [DW-1:0]     s_wdata;
  logic [NS-1:0]     s_rsp_valid = '0;
  logic [NS*DW-1:0]  s_rsp_rdata = '0;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [AW-1:0]     err_addr;
  logic [7:0]        err_count;
  logic              err_clear = 1'b0;

  addr_router #(
    .NUM_SLAVES (NS), .ADDR_W (AW), .DATA_W (DW), .REGION_BITS (RB),
    .REGION_IDX (RIDX), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .m_req_valid (m_req_valid), .m_req_ready (m_req_ready), .m_req_addr (m_req_addr),
    .m_req_we (m_req_we), .m_req_wdata (m_req_wdata),
    .m_rsp_valid (m_rsp_valid), .m_rsp_rdata (m_rsp_rdata), .m_rsp_err (m_rsp_err),
    .s_req_valid (s_req_valid), .s_req_ready (s_req_ready), .s_addr (s_addr),
    .s_we (s_we), .s_wdata (s_wdata), .s_rsp_valid (s_rsp_valid), .s_rsp_rdata (s_rsp_rdata),
    .err_valid (err_valid), .err_code (err_code), .err_addr (err_addr),
    .err_count (err_count), .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Region owned by each slave, in slave order.
  int unsigned regions [NS] = '{32'h0, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};

  // Reference error-capture state.
  bit          m_ev;
  logic [1:0]  m_code;
  logic [31:0] m_addr;
  int          m_cnt;

  typedef struct {
    int          cycle;
    logic [31:0] rdata;
    logic        err;
    logic [NS-1:0] sreq;
    logic        swe;
    logic [31:0] swdata;
    logic [31:0] saddr;
    logic [NS-1:0] sreq_at_rsp;
  } obs_t;

  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if (int'(a[31:16]) == int'(regions[i])) return i;
    return -1;
  endfunction

  task automatic ref_reset();
    m_ev = 0; m_code = 2'b00; m_addr = '0; m_cnt = 0;
  endtask

  // Predicts one transaction and advances the error-capture model.
  task automatic ref_step(input logic [31:0] addr, input logic we, input int wr, input int wp,
                          input logic [31:0] rd, input bit clr,
                          output int cyc, output logic [31:0] erd, output logic eerr);
    int t;
    logic [1:0] code;
    t = ref_slave(addr);
    if (clr) ref_reset();
    erd = '0; eerr = 1'b0; code = 2'b00;
    if (t < 0) begin
      cyc = 1; eerr = 1'b1; code = 2'b01;
    end else if (wr + wp + 2 > TO) begin
      cyc = TO + 1; eerr = 1'b1; code = 2'b10;
    end else begin
      cyc = wr + wp + 3; erd = we ? 32'h0 : rd;
    end
    if (eerr) begin
      if (!m_ev) begin m_ev = 1; m_code = code; m_addr = addr; end
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic noise(input int tgt);
    for (int j = 0; j < NS; j++) begin
      s_rsp_rdata[j*DW +: DW] = $urandom;
      if (j != tgt) begin
        s_req_ready[j] = 1'($urandom);
        s_rsp_valid[j] = 1'($urandom);
      end
    end
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wait_ready: m_req_ready=%0b required 1 within 20 cycles", m_req_ready); end
  endtask

  // Issues one request and plays the target slave: ready after wr REQ cycles,
  // response wp cycles after the handshake. Non-target slaves toggle randomly.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int tgt, input int wr, input int wp, input logic [31:0] rd,
                        input bit clr, output obs_t o);
    int rc = 0, pc = 0;
    bit hs = 0, in_rsp = 0;
    o.cycle = -1; o.rdata = '0; o.err = 1'b0; o.sreq = '0; o.swe = 1'b0;
    o.swdata = '0; o.saddr = '0; o.sreq_at_rsp = '0;
    wait_ready();
    m_req_valid = 1'b1; m_req_addr = addr; m_req_we = we; m_req_wdata = wdata; err_clear = clr;
    noise(tgt);
    @(negedge clk);
    m_req_valid = 1'b0; err_clear = 1'b0;
    m_req_addr = $urandom; m_req_we = 1'($urandom); m_req_wdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (s_req_valid != '0 && o.sreq == '0) begin
        o.sreq = s_req_valid; o.swe = s_we; o.swdata = s_wdata; o.saddr = s_addr;
      end
      if (m_rsp_valid) begin
        o.cycle = k; o.rdata = m_rsp_rdata; o.err = m_rsp_err; o.sreq_at_rsp = s_req_valid;
        break;
      end
      noise(tgt);
      if (tgt >= 0) begin
        s_req_ready[tgt] = 1'b0; s_rsp_valid[tgt] = 1'b0;
        if (hs) in_rsp = 1;
        hs = 0;
        if (in_rsp) begin
          if (pc == wp) begin s_rsp_valid[tgt] = 1'b1; s_rsp_rdata[tgt*DW +: DW] = rd; end
          pc++;
        end else if (s_req_valid[tgt]) begin
          if (rc == wr) begin s_req_ready[tgt] = 1'b1; hs = 1; end
          rc++;
        end
      end
      @(negedge clk);
    end
    s_req_ready = '0; s_rsp_valid = '0;
  endtask

  task automatic test_reset();
    logic [156:0] outs;
    #2;
    outs = {m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, s_req_valid, s_addr, s_we,
            s_wdata, err_valid, err_code, err_addr, err_count};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", outs); end
    ref_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_ready();
  endtask

  task automatic test_read_hit();
    obs_t o;
    int c; logic [31:0] d; logic e;
    ref_step(32'h0000_0010, 1'b0, 0, 0, 32'hDEADBEEF, 0, c, d, e);
    do_txn(32'h0000_0010, 1'b0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0, o);
    n_tests++; if (o.cycle !== 3) begin n_fail++; $display("FAIL read_latency: got %0d required 3", o.cycle); end
    n_tests++; if (o.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata: got %h required deadbeef", o.rdata); end
    n_tests++; if (o.err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b required 0", o.err); end
    n_tests++; if (o.sreq !== 6'b000001) begin n_fail++; $display("FAIL read_sreq: got %b required 000001", o.sreq); end
    n_tests++; if (o.saddr !== 32'h10) begin n_fail++; $display("FAIL read_saddr: got %h required 00000010", o.saddr); end
  endtask

  task automatic test_write();
    obs_t o;
    int c; logic [31:0] d; logic e;
    ref_step(32'h0004_0000, 1'b1, 1, 2, 32'hA5A5_0001, 0, c, d, e);
    do_txn(32'h0004_0000, 1'b1, 32'h5, 3, 1, 2, 32'hA5A5_0001, 0, o);
    n_tests++; if (o.sreq !== 6'b001000) begin n_fail++; $display("FAIL write_sreq: got %b required 001000", o.sreq); end
    n_tests++; if (o.swe !== 1'b1 || o.swdata !== 32'h5) begin n_fail++; $display("FAIL write_bus: got we=%b wdata=%h required we=1 wdata=5", o.swe, o.swdata); end
    n_tests++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin n_fail++; $display("FAIL write_rsp: got rdata=%h err=%b required 0/0", o.rdata, o.err); end
    n_tests++; if (o.cycle !== c) begin n_fail++; $display("FAIL write_latency: got %0d required %0d", o.cycle, c); end
  endtask

  task automatic test_decode_miss();
    obs_t o;
    int c; logic [31:0] d; logic e;
    ref_step(32'h0001_0000, 1'b0, 0, 0, 32'h0, 0, c, d, e);
    do_txn(32'h0001_0000, 1'b0, 32'h0, -1, 0, 0, 32'h0, 0, o);
    n_tests++; if (o.cycle !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL miss_rsp: got cyc=%0d err=%b rdata=%h required 1/1/0", o.cycle, o.err, o.rdata); end
    n_tests++; if (o.sreq !== '0) begin n_fail++; $display("FAIL miss_sreq: got %b required 0", o.sreq); end
    n_tests++; if (err_valid !== 1'b1 || err_code !== 2'b01 || err_addr !== 32'h0001_0000 || err_count !== 8'd1)
      begin n_fail++; $display("FAIL miss_capture: got v=%b code=%b addr=%h cnt=%0d required 1/01/00010000/1", err_valid, err_code, err_addr, err_count); end
  endtask

  task automatic test_timeout();
    obs_t o;
    int c; logic [31:0] d; logic e;
    // Never ready: sticky code from the earlier miss is kept.
    ref_step(32'h0003_0004, 1'b0, 99, 0, 32'h0, 0, c, d, e);
    do_txn(32'h0003_0004, 1'b0, 32'h0, 2, 99, 0, 32'h0, 0, o);
    n_tests++; if (o.cycle !== TO + 1 || o.err !== 1'b1) begin n_fail++; $display("FAIL tmo_noready: got cyc=%0d err=%b required %0d/1", o.cycle, o.err, TO + 1); end
    n_tests++; if (o.sreq_at_rsp !== '0) begin n_fail++; $display("FAIL tmo_sreq_drop: got %b required 0", o.sreq_at_rsp); end
    n_tests++; if (err_code !== 2'b01 || err_count !== 8'd2 || err_addr !== 32'h0001_0000)
      begin n_fail++; $display("FAIL tmo_sticky: got code=%b cnt=%0d addr=%h required 01/2/00010000", err_code, err_count, err_addr); end
    // Cleared at accept, then handshake without response.
    ref_step(32'h0003_0008, 1'b0, 0, 99, 32'h0, 1, c, d, e);
    do_txn(32'h0003_0008, 1'b0, 32'h0, 2, 0, 99, 32'h0, 1, o);
    n_tests++; if (o.cycle !== TO + 1 || o.err !== 1'b1) begin n_fail++; $display("FAIL tmo_norsp: got cyc=%0d err=%b required %0d/1", o.cycle, o.err, TO + 1); end
    n_tests++; if (err_valid !== 1'b1 || err_code !== 2'b10 || err_addr !== 32'h0003_0008 || err_count !== 8'd1)
      begin n_fail++; $display("FAIL tmo_capture: got v=%b code=%b addr=%h cnt=%0d required 1/10/00030008/1", err_valid, err_code, err_addr, err_count); end
  endtask

  task automatic test_random();
    obs_t o;
    int c, t, wr, wp;
    logic [31:0] d, a, wd, rd;
    logic e, we;
    bit clr;
    for (int n = 0; n < 60; n++) begin
      a  = {16'($urandom_range(0, 7)), 16'($urandom)};
      if (n % 10 == 9) a[31:16] = 16'($urandom);
      we = 1'($urandom); wd = $urandom; rd = $urandom;
      wr = $urandom_range(0, 5); wp = $urandom_range(0, 5);
      clr = ($urandom_range(0, 7) == 0);
      t = ref_slave(a);
      ref_step(a, we, wr, wp, rd, clr, c, d, e);
      do_txn(a, we, wd, t, wr, wp, rd, clr, o);
      n_tests++;
      if (o.cycle !== c || o.err !== e || o.rdata !== d)
        begin n_fail++; $display("FAIL rand_rsp[%0d]: got cyc=%0d err=%b rdata=%h required %0d/%b/%h", n, o.cycle, o.err, o.rdata, c, e, d); end
      n_tests++;
      if (o.sreq !== ((t < 0) ? 6'b0 : 6'(1 << t)))
        begin n_fail++; $display("FAIL rand_sreq[%0d]: got %b required slave %0d", n, o.sreq, t); end
      if (t >= 0) begin
        n_tests++;
        if (o.saddr !== a || o.swe !== we || o.swdata !== wd)
          begin n_fail++; $display("FAIL rand_bus[%0d]: got %h/%b/%h required %h/%b/%h", n, o.saddr, o.swe, o.swdata, a, we, wd); end
      end
      n_tests++;
      if (err_valid !== m_ev || err_code !== m_code || err_addr !== m_addr || int'(err_count) != m_cnt)
        begin n_fail++; $display("FAIL rand_errs[%0d]: got %b/%b/%h/%0d required %b/%b/%h/%0d", n, err_valid, err_code, err_addr, err_count, m_ev, m_code, m_addr, m_cnt); end
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    int c; logic [31:0] d, a; logic e;
    for (int n = 0; n < 300; n++) begin
      a = {16'($urandom_range(7, 16'hFFFF)), 16'($urandom)};
      if (n % 2 == 0) a[31:16] = 16'h1;
      ref_step(a, 1'b0, 0, 0, 32'h0, 0, c, d, e);
      do_txn(a, 1'b0, 32'h0, -1, 0, 0, 32'h0, 0, o);
      if (n == 9) begin
        n_tests++;
        if (int'(err_count) != m_cnt) begin n_fail++; $display("FAIL sat_mid: got %0d required %0d", err_count, m_cnt); end
      end
    end
    n_tests++;
    if (err_count !== 8'd255 || err_valid !== 1'b1) begin n_fail++; $display("FAIL sat_count: got cnt=%0d v=%b required 255/1", err_count, err_valid); end
    ref_step(32'h0007_0042, 1'b0, 0, 0, 32'h0, 1, c, d, e);
    do_txn(32'h0007_0042, 1'b0, 32'h0, -1, 0, 0, 32'h0, 1, o);
    n_tests++;
    if (err_valid !== 1'b1 || err_count !== 8'd1 || err_addr !== 32'h0007_0042 || err_code !== 2'b01)
      begin n_fail++; $display("FAIL clear_and_err: got v=%b cnt=%0d addr=%h code=%b required 1/1/00070042/01", err_valid, err_count, err_addr, err_code); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int c; logic [31:0] d; logic e;
    ref_step(32'h0006_0000, 1'b0, 0, 0, 32'h1111_2222, 0, c, d, e);
    do_txn(32'h0006_0000, 1'b0, 32'h0, 5, 0, 0, 32'h1111_2222, 0, o);
    n_tests++; if (o.cycle !== 3 || o.rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_first: got cyc=%0d rdata=%h required 3/11112222", o.cycle, o.rdata); end
    n_tests++; if (m_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_rsp: got %b required 0", m_req_ready); end
    m_req_valid = 1'b1; m_req_addr = 32'h00F0_0000; m_req_we = 1'b0;
    ref_step(32'h00F0_0000, 1'b0, 0, 0, 32'h0, 0, c, d, e);
    @(negedge clk);
    n_tests++; if (m_req_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got ready=%b rsp=%b required 1/0", m_req_ready, m_rsp_valid); end
    @(negedge clk);
    m_req_valid = 1'b0;
    n_tests++; if (m_rsp_valid !== 1'b1 || m_rsp_err !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got rsp=%b err=%b required 1/1", m_rsp_valid, m_rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int c; logic [31:0] d; logic e;
    logic [156:0] outs;
    bit seen = 0;
    wait_ready();
    m_req_valid = 1'b1; m_req_addr = 32'h0002_0040; m_req_we = 1'b0;
    @(negedge clk);
    m_req_valid = 1'b0;
    s_req_ready[1] = 1'b1;
    @(negedge clk);
    s_req_ready[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    outs = {m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, s_req_valid, s_addr, s_we,
            s_wdata, err_valid, err_code, err_addr, err_count};
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h required 0", outs); end
    ref_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    s_rsp_valid[1] = 1'b1; s_rsp_rdata[DW +: DW] = 32'h1234;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (m_rsp_valid) seen = 1; end
    s_rsp_valid[1] = 1'b0;
    n_tests++; if (seen) begin n_fail++; $display("FAIL midreset_no_rsp: got response after reset, required none"); end
    ref_step(32'h0005_1234, 1'b0, 2, 1, 32'hCAFE_F00D, 0, c, d, e);
    do_txn(32'h0005_1234, 1'b0, 32'h0, 4, 2, 1, 32'hCAFE_F00D, 0, o);
    n_tests++; if (o.cycle !== c || o.rdata !== d || o.err !== e || err_count !== 8'd0)
      begin n_fail++; $display("FAIL midreset_next: got cyc=%0d rdata=%h err=%b cnt=%0d required %0d/%h/%b/0", o.cycle, o.rdata, o.err, err_count, c, d, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_write();
    test_decode_miss();
    test_timeout();
    test_random();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
